sdram_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the SDRAM controller. It shares the single 16-bit-organised SDRAM between the instruction-fetch port (read-only, word) and the data port (read/write, byte/halfword/word). It converts byte addresses to the controller's halfword address plus odd flag, rejects unsupported misaligned words, and runs the controller's enable/ready handshake. It returns width-aligned read data with a one-cycle done pulse per requester.

---
 rtl/sdram_arbiter.sv | 145 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Two-port arbiter and sequencer in front of the 16-bit SDRAM controller.
// The data port normally wins. After MAX_STREAK consecutive data grants, a waiting ifetch is forced through.
module sdram_arbiter #(
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic        clk25m,
    input  logic        rst,
    input  logic        if_req,
    input  logic [24:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_err,
    input  logic        d_req,
    input  logic [24:0] d_addr,
    input  logic        d_we,
    input  logic [1:0]  d_width,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_err,
    output logic        mem_enable,
    output logic [23:0] mem_addr,
    output logic        mem_odd,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_width,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int unsigned SW     = $clog2(MAX_STREAK + 1);
    localparam logic [1:0]  W_BYTE = 2'b00;
    localparam logic [1:0]  W_HALF = 2'b01;
    localparam logic [1:0]  W_WORD = 2'b10;
    localparam logic [1:0]  W_BAD  = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH} state_t;

    state_t        state_q;
    logic          owner_if_q;
    logic [SW-1:0] streak_q;

    logic          grant_c;
    logic          pick_if_c;
    logic          pick_err_c;
    logic [31:0]   shifted_c;
    logic [31:0]   rd_fmt_c;

    // Arbitration and grant-time error check
    always_comb begin
        grant_c    = (state_q == IDLE) && mem_ready && (if_req || d_req);
        pick_if_c  = if_req && (!d_req || (streak_q == SW'(MAX_STREAK)));
        pick_err_c = pick_if_c ? if_addr[0]
                               : ((d_width == W_BAD) || ((d_width == W_WORD) && d_addr[0]));
    end

    // Odd accesses arrive from the controller one byte high
    always_comb begin
        shifted_c = mem_odd ? {8'h00, mem_rdata[31:8]} : mem_rdata;
        case (mem_width)
            W_BYTE:  rd_fmt_c = {24'h000000, shifted_c[7:0]};
            W_HALF:  rd_fmt_c = {16'h0000, shifted_c[15:0]};
            default: rd_fmt_c = shifted_c;
        endcase
    end

    always_ff @(posedge clk25m) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_if_q <= 1'b0;
            streak_q   <= '0;
            if_rdata   <= '0;
            if_done    <= 1'b0;
            if_err     <= 1'b0;
            d_rdata    <= '0;
            d_done     <= 1'b0;
            d_err      <= 1'b0;
            mem_enable <= 1'b0;
            mem_addr   <= '0;
            mem_odd    <= 1'b0;
            mem_write  <= 1'b0;
            mem_wdata  <= '0;
            mem_width  <= '0;
        end else begin
            mem_enable <= 1'b0;
            if_done    <= 1'b0;
            if_err     <= 1'b0;
            d_done     <= 1'b0;
            d_err      <= 1'b0;
            if (!if_req) begin
                streak_q <= '0;
            end

            case (state_q)
                IDLE: begin
                    if (grant_c) begin
                        if (pick_err_c) begin
                            if (pick_if_c) if_err <= 1'b1;
                            else           d_err  <= 1'b1;
                        end else begin
                            owner_if_q <= pick_if_c;
                            mem_enable <= 1'b1;
                            state_q    <= ISSUE;
                            if (pick_if_c) begin
                                mem_addr  <= if_addr[24:1];
                                mem_odd   <= if_addr[0];
                                mem_write <= 1'b0;
                                mem_wdata <= '0;
                                mem_width <= W_WORD;
                                streak_q  <= '0;
                            end else begin
                                mem_addr  <= d_addr[24:1];
                                mem_odd   <= d_addr[0];
                                mem_write <= d_we;
                                mem_wdata <= d_wdata;
                                mem_width <= d_width;
                                if (if_req && (streak_q < SW'(MAX_STREAK))) begin
                                    streak_q <= streak_q + SW'(1);
                                end
                            end
                        end
                    end
                end
                ISSUE: state_q <= WAIT_LOW;
                WAIT_LOW: begin
                    if (!mem_ready) state_q <= WAIT_HIGH;
                end
                WAIT_HIGH: begin
                    if (mem_ready) begin
                        state_q <= IDLE;
                        if (owner_if_q) begin
                            if_done <= 1'b1;
                            if (!mem_write) if_rdata <= rd_fmt_c;
                        end else begin
                            d_done <= 1'b1;
                            if (!mem_write) d_rdata <= rd_fmt_c;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small behavioural SDRAM controller model
// (6-cycle busy period after each enable).
module tb_sdram_arbiter;

    logic        clk25m = 1'b0;
    logic        rst;
    logic        if_req;
    logic [24:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_err;
    logic        d_req;
    logic [24:0] d_addr;
    logic        d_we;
    logic [1:0]  d_width;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        d_err;
    logic        mem_enable;
    logic [23:0] mem_addr;
    logic        mem_odd;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_width;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    always #20 clk25m = ~clk25m;

    sdram_arbiter dut (
        .clk25m(clk25m), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .if_err(if_err),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_width(d_width),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
        .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_odd(mem_odd),
        .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_width(mem_width),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    // Controller model: holds ready low while initialising, then is busy for 6 cycles per enable
    logic        init_hold;
    logic        force_en;
    logic [31:0] force_val;
    int          busy_cnt = 0;
    logic [31:0] rd_q = '0;
    logic [31:0] memarr [0:15] = '{default: '0};

    assign mem_ready = !init_hold && (busy_cnt == 0);
    assign mem_rdata = rd_q;

    always @(posedge clk25m) begin
        if (rst) begin
            busy_cnt <= 0;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end else if (mem_enable && !init_hold) begin
            busy_cnt <= 6;
            if (mem_write) memarr[mem_addr[3:0]] <= mem_wdata;
            else           rd_q <= force_en ? force_val : memarr[mem_addr[3:0]];
        end
    end

    // Pulse monitor: enable count, completion order (1 = ifetch), illegal pulse overlaps
    int          en_cnt = 0;
    int          seq_cnt = 0;
    int          overlap_cnt = 0;
    logic [31:0] seq_bits = '0;

    always @(negedge clk25m) begin
        if (mem_enable) en_cnt <= en_cnt + 1;
        if (if_done || d_done) begin
            seq_cnt  <= seq_cnt + 1;
            seq_bits <= {seq_bits[30:0], if_done};
        end
        if (((if_done || if_err) && (d_done || d_err)) || (if_done && if_err) || (d_done && d_err))
            overlap_cnt <= overlap_cnt + 1;
    end

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_cycle();
        @(posedge clk25m);
        #1;
    endtask

    task automatic d_access(input logic [24:0] addr, input logic we, input logic [1:0] w,
                            input logic [31:0] wd, output int cyc);
        d_addr  = addr;
        d_we    = we;
        d_width = w;
        d_wdata = wd;
        d_req   = 1'b1;
        cyc     = 0;
        do begin
            wait_cycle();
            cyc++;
        end while (!d_done && !d_err && cyc < 100);
        d_req = 1'b0;
    endtask

    task automatic if_access(input logic [24:0] addr, output int cyc);
        if_addr = addr;
        if_req  = 1'b1;
        cyc     = 0;
        do begin
            wait_cycle();
            cyc++;
        end while (!if_done && !if_err && cyc < 100);
        if_req = 1'b0;
    endtask

    initial begin
        int cyc;
        int bad;
        int e0;
        int s0;
        int n;

        rst = 1'b1; init_hold = 1'b1; force_en = 1'b0; force_val = '0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_addr = '0; d_we = 1'b0; d_width = 2'b00; d_wdata = '0;
        repeat (3) wait_cycle();
        check_eq("rst_ctrl", 32'({if_done, if_err, d_done, d_err, mem_enable, mem_odd, mem_write, mem_width}), 32'h0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'h0);
        check_eq("rst_data", if_rdata | d_rdata | mem_wdata, 32'h0);

        // Controller initialising: no grant while mem_ready is low
        rst = 1'b0;
        d_addr = 25'h10; d_we = 1'b0; d_width = 2'b10; d_req = 1'b1;
        bad = 0;
        repeat (200) begin
            wait_cycle();
            if (mem_enable || d_done || d_err) bad++;
        end
        check_eq("init_blocked", 32'(bad), 32'h0);
        init_hold = 1'b0;
        wait_cycle();
        check_eq("init_enable_n1", 32'(mem_enable), 32'h1);
        check_eq("init_mem_addr", 32'(mem_addr), 32'h8);
        cyc = 1;
        while (!d_done && cyc < 100) begin
            wait_cycle();
            cyc++;
        end
        d_req = 1'b0;
        check_eq("init_latency", 32'(cyc), 32'd9);
        check_eq("init_rdata", d_rdata, 32'h0);
        wait_cycle();
        check_eq("init_done_pulse", 32'(d_done), 32'h0);

        // Word write then read-back
        e0 = en_cnt;
        d_access(25'h10, 1'b1, 2'b10, 32'hDEADBEEF, cyc);
        check_eq("wr_latency", 32'(cyc), 32'd9);
        check_eq("wr_done", 32'(d_done), 32'h1);
        check_eq("wr_fields", 32'({mem_addr, mem_odd, mem_write, mem_width}), {24'h000008, 1'b0, 1'b1, 2'b10});
        check_eq("wr_wdata", mem_wdata, 32'hDEADBEEF);
        check_eq("wr_rdata_kept", d_rdata, 32'h0);
        wait_cycle();
        check_eq("wr_done_pulse", 32'(d_done), 32'h0);
        check_eq("wr_enables", 32'(en_cnt - e0), 32'd1);
        d_access(25'h10, 1'b0, 2'b10, 32'h0, cyc);
        check_eq("rd_done", 32'(d_done), 32'h1);
        check_eq("rd_word", d_rdata, 32'hDEADBEEF);
        wait_cycle();

        // Odd halfword / byte reads
        force_en = 1'b1; force_val = 32'h00AABBCC;
        d_access(25'h11, 1'b0, 2'b01, 32'h0, cyc);
        check_eq("hw_addr", 32'({mem_addr, mem_odd}), {7'h0, 24'h000008, 1'b1});
        check_eq("hw_rdata", d_rdata, 32'h0000AABB);
        wait_cycle();
        d_access(25'h11, 1'b0, 2'b00, 32'h0, cyc);
        check_eq("byte_odd_rdata", d_rdata, 32'h000000BB);
        wait_cycle();
        d_access(25'h10, 1'b0, 2'b00, 32'h0, cyc);
        check_eq("byte_even_rdata", d_rdata, 32'h000000CC);
        wait_cycle();
        d_access(25'h11, 1'b0, 2'b00, 32'h0, cyc);
        wait_cycle();

        // Error cases: one-cycle err, no memory access
        e0 = en_cnt;
        d_access(25'h3, 1'b0, 2'b10, 32'h0, cyc);
        check_eq("err_word_odd", 32'({d_err, d_done}), 32'h2);
        check_eq("err_latency", 32'(cyc), 32'd1);
        wait_cycle();
        check_eq("err_pulse", 32'(d_err), 32'h0);
        d_access(25'h10, 1'b0, 2'b11, 32'h0, cyc);
        check_eq("err_width11", 32'({d_err, d_done}), 32'h2);
        wait_cycle();
        if_access(25'h1, cyc);
        check_eq("err_if_odd", 32'({if_err, if_done}), 32'h2);
        wait_cycle();
        check_eq("err_if_pulse", 32'(if_err), 32'h0);
        check_eq("err_no_enable", 32'(en_cnt - e0), 32'h0);

        // Ifetch word read
        force_val = 32'h12345678;
        if_access(25'h20, cyc);
        check_eq("if_done", 32'(if_done), 32'h1);
        check_eq("if_fields", 32'({mem_addr, mem_odd, mem_write, mem_width}), {24'h000010, 1'b0, 1'b0, 2'b10});
        check_eq("if_rdata", if_rdata, 32'h12345678);
        check_eq("if_d_rdata_kept", d_rdata, 32'h000000BB);
        wait_cycle();

        // Both ports requesting continuously: streak forces ifetch every fifth grant
        s0 = seq_cnt;
        if_addr = 25'h20; d_addr = 25'h10; d_we = 1'b0; d_width = 2'b10;
        if_req = 1'b1; d_req = 1'b1;
        n = 0; cyc = 0;
        while (n < 10 && cyc < 400) begin
            wait_cycle();
            cyc++;
            if (if_done || d_done) n++;
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (3) wait_cycle();
        check_eq("streak_count", 32'(seq_cnt - s0), 32'd10);
        check_eq("streak_order", {22'h0, seq_bits[9:0]}, 32'h021);

        // Reset in WAIT_HIGH aborts with no done
        force_val = 32'h00AABBCC;
        d_addr = 25'h10; d_width = 2'b10; d_req = 1'b1;
        repeat (5) wait_cycle();
        rst = 1'b1; init_hold = 1'b1; d_req = 1'b0;
        s0 = seq_cnt;
        wait_cycle();
        check_eq("abort_ctrl", 32'({if_done, if_err, d_done, d_err, mem_enable, mem_odd, mem_write, mem_width}), 32'h0);
        check_eq("abort_data", d_rdata | if_rdata | mem_wdata | 32'(mem_addr), 32'h0);
        rst = 1'b0;
        repeat (10) wait_cycle();
        check_eq("abort_no_done", 32'(seq_cnt - s0), 32'h0);
        init_hold = 1'b0;
        d_access(25'h11, 1'b0, 2'b00, 32'h0, cyc);
        check_eq("post_rst_latency", 32'(cyc), 32'd9);
        check_eq("post_rst_rdata", d_rdata, 32'h000000BB);
        wait_cycle();

        check_eq("pulse_overlap", 32'(overlap_cnt), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
